// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 serial receiver with mid-bit sampling and a valid/ready byte output.
// Define RS232_RX_PARITY_EN to expect an even parity bit between bit 7 and the stop bit.
module rs232_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       OG_clk,
    input  logic       reset,
    input  logic       Rx,
    output logic [7:0] r_data,
    output logic       r_valid,
    input  logic       r_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, rx_s_q, rx_p_q;
    logic [2:0]     arm_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ovr_q, ovr_d;
    logic           ferr_q, ferr_d;
    logic           deliver;
    logic           accept;
    logic           cnt_half, cnt_last;
`ifdef RS232_RX_PARITY_EN
    logic           par_q, par_d;
    logic           perr_q, perr_d;
`endif

    assign accept   = valid_q & r_ready;
    assign cnt_half = (cnt_q == CNT_HALF);
    assign cnt_last = (cnt_q == CNT_LAST);

    // arm_q[2] is set only once rx_p reflects the real line, so a line held low
    // through reset release never looks like a falling edge.
    always_ff @(posedge OG_clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_p_q  <= 1'b1;
            arm_q   <= 3'b000;
        end else begin
            sync1_q <= Rx;
            rx_s_q  <= sync1_q;
            rx_p_q  <= rx_s_q;
            arm_q   <= {arm_q[1:0], 1'b1};
        end
    end

    always_ff @(posedge OG_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
`ifdef RS232_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (arm_q[2] && !rx_s_q && rx_p_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_half) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef RS232_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_IDLE;
`ifdef RS232_RX_PARITY_EN
                        if (^{shift_q, par_q}) perr_d  = 1'b1;
                        else                   deliver = 1'b1;
`else
                        deliver = 1'b1;
`endif
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // An accept in the delivery cycle frees the slot, so the new byte is taken.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (deliver) begin
            if (!valid_q || r_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                if (valid_q) ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign r_data    = data_q;
    assign r_valid   = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;
`ifdef RS232_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx: scoreboard of expected bytes against observed transfers.
`timescale 1ns/1ps
module tb_rs232_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef RS232_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int STOP_EDGE = 2 + H + (NBITS - 1) * CPB;
    localparam int FRAME     = NBITS * CPB;

    logic       OG_clk;
    logic       reset;
    logic       Rx;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    rs232_rx #(.CLKS_PER_BIT(CPB)) dut (
        .OG_clk     (OG_clk),
        .reset      (reset),
        .Rx         (Rx),
        .r_data     (r_data),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial OG_clk = 1'b0;
    always #5 OG_clk = ~OG_clk;

    typedef struct {
        logic [7:0] d;
        int         c;
    } obs_t;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         t0;
    int         rise_cyc = -1;
    int         n_rise = 0;
    int         n_ferr = 0;
    int         ferr_cyc = -1;
    int         n_perr = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];
    obs_t       obs_q[$];
`ifdef RS232_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    always @(posedge OG_clk) cyc = cyc + 1;

    // Observation only: transfers, r_valid rises and status pulses with their edge index.
    always @(negedge OG_clk) begin
        if (r_valid && !prev_valid) begin
            rise_cyc = cyc;
            n_rise   = n_rise + 1;
        end
        prev_valid = r_valid;
        if (r_valid && r_ready) obs_q.push_back('{r_data, cyc});
        if (frame_err) begin
            n_ferr   = n_ferr + 1;
            ferr_cyc = cyc;
        end
        if (parity_err) n_perr = n_perr + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge OG_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        Rx = 1'b0;
        t0 = cyc + 1;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            repeat (CPB) tick();
        end
`ifdef RS232_RX_PARITY_EN
        Rx = (^d) ^ par_flip;
        repeat (CPB) tick();
`endif
        Rx = stop_bit;
        repeat (CPB) tick();
    endtask

    task automatic check_one_transfer(input string name);
        logic [7:0] e;
        obs_t       o;
        tests++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            fails++;
            $display("FAIL %s: transfers=%0d expected-queue=%0d, required 1 and 1", name, obs_q.size(), exp_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.d !== e) begin
                fails++;
                $display("FAIL %s: data got %h required %h", name, o.d, e);
            end
        end
    endtask

    task automatic test_reset();
        Rx = 1'b1; r_ready = 1'b0; reset = 1'b0;
        repeat (3) tick();
        tests++; if (r_valid !== 1'b0)   begin fails++; $display("FAIL rst_valid: got %b required 0", r_valid); end
        tests++; if (r_data !== 8'h00)   begin fails++; $display("FAIL rst_data: got %h required 00", r_data); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_ferr: got %b required 0", frame_err); end
        tests++; if (overrun !== 1'b0)   begin fails++; $display("FAIL rst_ovr: got %b required 0", overrun); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL rst_perr: got %b required 0", parity_err); end
        // line held low across reset release is not a start
        Rx = 1'b0;
        tick();
        reset = 1'b1;
        repeat (FRAME + 40) tick();
        Rx = 1'b1;
        repeat (10) tick();
        tests++; if (n_rise !== 0) begin fails++; $display("FAIL low_at_release_valid: rises %0d required 0", n_rise); end
        tests++; if (n_ferr !== 0) begin fails++; $display("FAIL low_at_release_ferr: pulses %0d required 0", n_ferr); end
    endtask

    task automatic test_single();
        r_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tests++; if (rise_cyc !== t0 + STOP_EDGE) begin fails++; $display("FAIL single_latency: rise at edge %0d required %0d", rise_cyc - t0, STOP_EDGE); end
        tests++; if (r_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b required 1", r_valid); end
        tests++; if (r_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h required a5", r_data); end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        tick();
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL single_accept_valid: got %b required 0", r_valid); end
        tests++; if (r_data !== 8'hA5) begin fails++; $display("FAIL single_hold_data: got %h required a5", r_data); end
        check_one_transfer("single_transfer");
    endtask

    task automatic test_back_to_back();
        int   ta;
        obs_t o0, o1;
        r_ready = 1'b1;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        ta = t0;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        repeat (10) tick();
        r_ready = 1'b0;
        tests++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
            fails++;
            $display("FAIL b2b_count: transfers %0d required 2", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            o0 = obs_q.pop_front();
            o1 = obs_q.pop_front();
            tests++; if (o0.d !== exp_q[0]) begin fails++; $display("FAIL b2b_data0: got %h required %h", o0.d, exp_q[0]); end
            tests++; if (o1.d !== exp_q[1]) begin fails++; $display("FAIL b2b_data1: got %h required %h", o1.d, exp_q[1]); end
            tests++; if (o0.c !== ta + STOP_EDGE) begin fails++; $display("FAIL b2b_latency: edge %0d required %0d", o0.c - ta, STOP_EDGE); end
            tests++; if (o1.c - o0.c !== FRAME) begin fails++; $display("FAIL b2b_spacing: got %0d required %0d", o1.c - o0.c, FRAME); end
            exp_q.delete();
        end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b required 0", overrun); end
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = n_rise; f0 = n_ferr;
        r_ready = 1'b0;
        Rx = 1'b0;
        repeat (3) tick();
        Rx = 1'b1;
        repeat (FRAME + 20) tick();
        tests++; if (n_rise !== r0) begin fails++; $display("FAIL glitch_valid: rises %0d required 0", n_rise - r0); end
        tests++; if (n_ferr !== f0) begin fails++; $display("FAIL glitch_ferr: pulses %0d required 0", n_ferr - f0); end
        r_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (5) tick();
        r_ready = 1'b0;
        check_one_transfer("glitch_rearm");
    endtask

    task automatic test_frame_err();
        int r0, f0;
        r0 = n_rise; f0 = n_ferr;
        r_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        repeat (40) tick();
        Rx = 1'b1;
        repeat (20) tick();
        tests++; if (n_ferr - f0 !== 1) begin fails++; $display("FAIL ferr_pulses: got %0d required 1", n_ferr - f0); end
        tests++; if (ferr_cyc !== t0 + STOP_EDGE) begin fails++; $display("FAIL ferr_time: edge %0d required %0d", ferr_cyc - t0, STOP_EDGE); end
        tests++; if (n_rise !== r0) begin fails++; $display("FAIL ferr_no_valid: rises %0d required 0", n_rise - r0); end
        r_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (5) tick();
        r_ready = 1'b0;
        check_one_transfer("ferr_recover");
    endtask

    task automatic test_overrun();
        r_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (5) tick();
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b required 1", overrun); end
        tests++; if (r_data !== 8'h11) begin fails++; $display("FAIL ovr_keep_data: got %h required 11", r_data); end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        tick();
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b required 0", overrun); end
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL ovr_accept_valid: got %b required 0", r_valid); end
        check_one_transfer("ovr_transfer");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h55;
        r_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        repeat (2) tick();
        tests++; if (r_valid !== 1'b1) begin fails++; $display("FAIL rmid_pending: got %b required 1", r_valid); end
        Rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            Rx = d[i];
            repeat (CPB) tick();
        end
        Rx = d[4];
        repeat (H) tick();
        reset = 1'b0;
        tick();
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b required 0", r_valid); end
        tests++; if (r_data !== 8'h00) begin fails++; $display("FAIL rmid_data: got %h required 00", r_data); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rmid_ovr: got %b required 0", overrun); end
        Rx = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_partial: got %b required 0", r_valid); end
        r_ready = 1'b1;
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        repeat (5) tick();
        r_ready = 1'b0;
        check_one_transfer("rmid_recover");
    endtask

`ifdef RS232_RX_PARITY_EN
    task automatic test_parity();
        int r0, p0;
        r0 = n_rise; p0 = n_perr;
        r_ready = 1'b0;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (5) tick();
        tests++; if (n_perr - p0 !== 1) begin fails++; $display("FAIL par_pulse: got %0d required 1", n_perr - p0); end
        tests++; if (n_rise !== r0) begin fails++; $display("FAIL par_no_valid: rises %0d required 0", n_rise - r0); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL par_no_ovr: got %b required 0", overrun); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
`ifdef RS232_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
